// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: direction-counter encodings,
// counter init values and the control opcodes the resolve stage decodes.
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam logic [3:0] OPC_BEQ = 4'h8;
  localparam logic [3:0] OPC_BNE = 4'h9;
  localparam logic [3:0] OPC_JMP = 4'hA;

  function automatic logic opc_is_jmp(input logic [3:0] opc);
    return (opc == OPC_JMP);
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating up/down counter next-state logic for the BTB direction
// predictor; up=1 moves toward strongly-taken.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_next
);

  // saturating increment/decrement
  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      else               ctr_next = CTR_ST;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      else                ctr_next = CTR_SNT;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters: combinational
// next-PC prediction for fetch, trained by the branch resolve stage.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int DBITS    = 16,
  parameter int ENTRIES  = 16,
  parameter int IDXBITS  = $clog2(ENTRIES),
  parameter int TAGBITS  = DBITS - IDXBITS - 1,
  parameter int PERFBITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    fetch_pc,
  output logic                pred_taken,
  output logic [DBITS-1:0]    pred_next_pc,
  input  logic                upd_valid,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic                upd_is_jmp,
  input  logic                upd_mispredict,
  input  logic                clear,
  output logic [PERFBITS-1:0] perf_updates,
  output logic [PERFBITS-1:0] perf_mispredicts
);

  logic                valid_r [ENTRIES];
  logic [TAGBITS-1:0]  tag_r   [ENTRIES];
  logic [DBITS-1:0]    tgt_r   [ENTRIES];
  logic [1:0]          ctr_r   [ENTRIES];
  logic                jmp_r   [ENTRIES];

  logic [PERFBITS-1:0] perf_updates_r;
  logic [PERFBITS-1:0] perf_mispredicts_r;

  logic [IDXBITS-1:0]  fidx_s;
  logic [TAGBITS-1:0]  ftag_s;
  logic                fhit_s;
  logic                ftaken_s;
  logic [IDXBITS-1:0]  uidx_s;
  logic [TAGBITS-1:0]  utag_s;
  logic                uhit_s;
  logic [1:0]          uctr_next_s;
  logic                unused_s;

  // PC[0] is always zero for 2-byte instructions
  assign unused_s = fetch_pc[0] ^ upd_pc[0];

  assign fidx_s = fetch_pc[IDXBITS:1];
  assign ftag_s = fetch_pc[DBITS-1:IDXBITS+1];
  assign uidx_s = upd_pc[IDXBITS:1];
  assign utag_s = upd_pc[DBITS-1:IDXBITS+1];

  // lookup reads table state only, so a same-cycle update is not bypassed
  always_comb begin
    fhit_s   = valid_r[fidx_s] && (tag_r[fidx_s] == ftag_s);
    ftaken_s = fhit_s && (jmp_r[fidx_s] || ctr_r[fidx_s][1]);
    if (ftaken_s) pred_next_pc = tgt_r[fidx_s];
    else          pred_next_pc = fetch_pc + {{(DBITS-2){1'b0}}, 2'd2};
  end

  assign pred_taken = ftaken_s;
  assign uhit_s     = valid_r[uidx_s] && (tag_r[uidx_s] == utag_s);

  btb_sat_ctr u_sat_ctr (
    .ctr      (ctr_r[uidx_s]),
    .up       (upd_taken),
    .ctr_next (uctr_next_s)
  );

  // table state: reset, clear (wins over training), then training
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= {TAGBITS{1'b0}};
        tgt_r[i]   <= {DBITS{1'b0}};
        ctr_r[i]   <= CTR_RESET;
        jmp_r[i]   <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_r[i] <= 1'b0;
    end else if (upd_valid) begin
      if (uhit_s) begin
        ctr_r[uidx_s] <= uctr_next_s;
        if (upd_taken) begin
          tgt_r[uidx_s] <= upd_target;
          jmp_r[uidx_s] <= upd_is_jmp;
        end
      end else if (upd_taken) begin
        valid_r[uidx_s] <= 1'b1;
        tag_r[uidx_s]   <= utag_s;
        tgt_r[uidx_s]   <= upd_target;
        ctr_r[uidx_s]   <= CTR_ALLOC;
        jmp_r[uidx_s]   <= upd_is_jmp;
      end
    end
  end

  // saturating performance counters, untouched by clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_updates_r     <= {PERFBITS{1'b0}};
      perf_mispredicts_r <= {PERFBITS{1'b0}};
    end else if (upd_valid) begin
      if (perf_updates_r != {PERFBITS{1'b1}})
        perf_updates_r <= perf_updates_r + {{(PERFBITS-1){1'b0}}, 1'b1};
      if (upd_mispredict && (perf_mispredicts_r != {PERFBITS{1'b1}}))
        perf_mispredicts_r <= perf_mispredicts_r + {{(PERFBITS-1){1'b0}}, 1'b1};
    end
  end

  assign perf_updates     = perf_updates_r;
  assign perf_mispredicts = perf_mispredicts_r;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor; a second instance with
// 4-bit perf counters exercises counter saturation.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        upd_valid, upd_taken, upd_is_jmp, upd_mispredict, clear;
  logic [15:0] upd_pc, upd_target;

  logic        pred_taken, pred_taken4;
  logic [15:0] pred_next_pc, pred_next_pc4;
  logic [15:0] perf_upd, perf_mis;
  logic [3:0]  perf_upd4, perf_mis4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int n_misp   = 0;

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jmp(upd_is_jmp),
    .upd_mispredict(upd_mispredict), .clear(clear),
    .perf_updates(perf_upd), .perf_mispredicts(perf_mis)
  );

  btb_predictor #(.PERFBITS(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken4), .pred_next_pc(pred_next_pc4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jmp(upd_is_jmp),
    .upd_mispredict(upd_mispredict), .clear(clear),
    .perf_updates(perf_upd4), .perf_mispredicts(perf_mis4)
  );

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic jmp, input logic misp);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_is_jmp = jmp; upd_mispredict = misp;
    n_upd++;
    if (misp) n_misp++;
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    look(16'h0200);
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", pred_taken); end
    n_checks++;
    if (pred_next_pc !== 16'h0202) begin n_fail++; $display("FAIL reset_next: got %h expected 0202", pred_next_pc); end
    n_checks++;
    if (perf_upd !== 16'h0000 || perf_mis !== 16'h0000) begin
      n_fail++; $display("FAIL reset_perf: got %h/%h expected 0000/0000", perf_upd, perf_mis);
    end
    look(16'hFFFE);
    n_checks++;
    if (pred_next_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: got %h expected 0000", pred_next_pc); end
  endtask

  task automatic test_train();
    upd(16'h0210, 1'b1, 16'h0240, 1'b0, 1'b0);
    look(16'h0210);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_next_pc !== 16'h0240) begin
      n_fail++; $display("FAIL train_alloc: got %b/%h expected 1/0240", pred_taken, pred_next_pc);
    end
    upd(16'h0210, 1'b0, 16'h0000, 1'b0, 1'b1);
    look(16'h0210);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0212) begin
      n_fail++; $display("FAIL train_wnt: got %b/%h expected 0/0212", pred_taken, pred_next_pc);
    end
    upd(16'h0210, 1'b0, 16'h0000, 1'b0, 1'b0);
    upd(16'h0210, 1'b1, 16'h0250, 1'b0, 1'b0);
    look(16'h0210);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0212) begin
      n_fail++; $display("FAIL train_snt_floor: got %b/%h expected 0/0212", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) upd(16'h0220, 1'b1, 16'h0280, 1'b0, 1'b0);
    upd(16'h0220, 1'b0, 16'h0000, 1'b0, 1'b0);
    look(16'h0220);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_next_pc !== 16'h0280) begin
      n_fail++; $display("FAIL sat_st_minus1: got %b/%h expected 1/0280", pred_taken, pred_next_pc);
    end
    upd(16'h0220, 1'b0, 16'h0000, 1'b0, 1'b0);
    look(16'h0220);
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_st_minus2: got %b expected 0", pred_taken); end
  endtask

  task automatic test_alias();
    upd(16'h0212, 1'b1, 16'h0260, 1'b0, 1'b0);
    upd(16'h0232, 1'b1, 16'h0270, 1'b0, 1'b0);
    look(16'h0212);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0214) begin
      n_fail++; $display("FAIL alias_old_miss: got %b/%h expected 0/0214", pred_taken, pred_next_pc);
    end
    look(16'h0232);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_next_pc !== 16'h0270) begin
      n_fail++; $display("FAIL alias_new_hit: got %b/%h expected 1/0270", pred_taken, pred_next_pc);
    end
    upd(16'h0212, 1'b0, 16'h0000, 1'b0, 1'b0);
    look(16'h0232);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_next_pc !== 16'h0270) begin
      n_fail++; $display("FAIL nt_miss_no_alloc: got %b/%h expected 1/0270", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_jmp_clear();
    upd(16'h0300, 1'b1, 16'h0400, 1'b1, 1'b1);
    upd(16'h0300, 1'b0, 16'h0000, 1'b1, 1'b0);
    upd(16'h0300, 1'b0, 16'h0000, 1'b1, 1'b0);
    look(16'h0300);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_next_pc !== 16'h0400) begin
      n_fail++; $display("FAIL jmp_override: got %b/%h expected 1/0400", pred_taken, pred_next_pc);
    end
    @(negedge clk);
    clear = 1'b1; upd_valid = 1'b1; upd_pc = 16'h0206; upd_taken = 1'b1;
    upd_target = 16'h0290; upd_is_jmp = 1'b0; upd_mispredict = 1'b0;
    n_upd++;
    look(16'h0300);
    n_checks++;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL no_bypass: got %b expected 1", pred_taken); end
    @(negedge clk);
    clear = 1'b0; upd_valid = 1'b0;
    look(16'h0300);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0302) begin
      n_fail++; $display("FAIL clear_invalid: got %b/%h expected 0/0302", pred_taken, pred_next_pc);
    end
    look(16'h0206);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0208) begin
      n_fail++; $display("FAIL clear_wins: got %b/%h expected 0/0208", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_perf();
    n_checks++;
    if (perf_upd !== 16'(n_upd) || perf_mis !== 16'(n_misp)) begin
      n_fail++; $display("FAIL perf_count: got %0d/%0d expected %0d/%0d", perf_upd, perf_mis, n_upd, n_misp);
    end
    for (int i = 0; i < 20; i++) upd(16'h0600, 1'b0, 16'h0000, 1'b0, 1'b1);
    n_checks++;
    if (perf_upd4 !== 4'hF || perf_mis4 !== 4'hF) begin
      n_fail++; $display("FAIL perf_sat4: got %h/%h expected F/F", perf_upd4, perf_mis4);
    end
    n_checks++;
    if (perf_upd !== 16'(n_upd) || perf_mis !== 16'(n_misp)) begin
      n_fail++; $display("FAIL perf_count16: got %0d/%0d expected %0d/%0d", perf_upd, perf_mis, n_upd, n_misp);
    end
  endtask

  task automatic test_async_reset();
    upd(16'h0500, 1'b1, 16'h0540, 1'b0, 1'b0);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 16'h0502; upd_taken = 1'b1; upd_target = 16'h0580;
    upd_mispredict = 1'b1;
    #2;
    reset = 1'b1;
    look(16'h0500);
    n_checks++;
    if (perf_upd !== 16'h0000 || perf_mis !== 16'h0000 || perf_upd4 !== 4'h0 || perf_mis4 !== 4'h0) begin
      n_fail++; $display("FAIL async_perf: got %h/%h/%h/%h expected 0", perf_upd, perf_mis, perf_upd4, perf_mis4);
    end
    n_checks++;
    if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0502) begin
      n_fail++; $display("FAIL async_table: got %b/%h expected 0/0502", pred_taken, pred_next_pc);
    end
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0; reset = 1'b0;
    look(16'h0502);
    n_checks++;
    if (pred_taken !== 1'b0 || perf_upd !== 16'h0000) begin
      n_fail++; $display("FAIL reset_discard: got %b/%h expected 0/0000", pred_taken, perf_upd);
    end
  endtask

  initial begin
    reset = 1'b1; fetch_pc = 16'h0000; clear = 1'b0;
    upd_valid = 1'b0; upd_pc = 16'h0000; upd_taken = 1'b0; upd_target = 16'h0000;
    upd_is_jmp = 1'b0; upd_mispredict = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_train();
    test_saturate();
    test_alias();
    test_jmp_clear();
    test_perf();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined 16-bit core. It sits beside the fetch stage: it predicts the next PC combinationally from the fetch PC and is trained by the stage that resolves BEQ/BNE/JMP. It replaces the fixed "always take BEQ/BNE target, always fall through JMP" policy, so that flushes occur only on real mispredictions.

## Interface
- DBITS, 16, address/data width
- ENTRIES, 16, number of BTB entries; power of two, ≥2
- IDXBITS, log2(ENTRIES), index width (derived)
- TAGBITS, DBITS-IDXBITS-1, tag width (derived)
- PERFBITS, 16, width of each performance counter

- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- fetch_pc  in  DBITS  PC of the instruction being fetched
- pred_taken  out  1  predicted taken/redirect
- pred_next_pc  out  DBITS  predicted next PC
- upd_valid  in  1  training event this cycle
- upd_pc  in  DBITS  PC of the resolved control instruction
- upd_taken  in  1  actual outcome (JMP is always 1)
- upd_target  in  DBITS  actual target when taken
- upd_is_jmp  in  1  resolved instruction is JMP
- upd_mispredict  in  1  resolve stage flushed for this instruction
- clear  in  1  synchronous invalidate of all entries
- perf_updates  out  PERFBITS  count of training events
- perf_mispredicts  out  PERFBITS  count of mispredicts

## Operation
- Addressing: PC[0] is ignored (2-byte instructions). index = PC[IDXBITS:1]; tag = PC[DBITS-1:IDXBITS+1]. Direct-mapped.
- Entry fields: valid, tag, target (DBITS), ctr (2 bits: 00 SNT, 01 WNT, 10 WT, 11 ST), is_jmp.
- Lookup (combinational): hit = valid && tag match. pred_taken = hit && (is_jmp || ctr[1]). pred_next_pc = pred_taken ? target : fetch_pc + 2, computed modulo 2^DBITS (0xFFFE + 2 = 0x0000).
- Update when upd_valid on posedge clk:
  - Hit, taken: ctr increments, saturating at 11; target and is_jmp are rewritten.
  - Hit, not taken: ctr decrements, saturating at 00; target is kept.
  - Miss, taken: allocate or overwrite the slot. valid=1, new tag, target, is_jmp, ctr=10.
  - Miss, not taken: no state change.
- clear: all valid bits go to 0 at the next edge. If clear and upd_valid occur in the same cycle, clear wins and no allocation happens. Perf counters are not affected by clear.
- Perf counters:
  - perf_updates increments on each upd_valid.
  - perf_mispredicts increments on upd_valid && upd_mispredict.
  - Both saturate at 2^PERFBITS-1 and never wrap.

## Timing
- Lookup: zero latency, pure combinational from fetch_pc and the table state.
- Update: visible to lookups starting the cycle after the edge that samples it.
- Same-index lookup and update in one cycle: the lookup sees the old entry. There is no bypass.
- Reset (asynchronous, effective immediately):
  - all valid=0, ctr=01, tag/target/is_jmp=0
  - perf counters = 0
  - therefore pred_taken=0 and pred_next_pc=fetch_pc+2
- Reset asserted mid-operation discards any update sampled in that cycle.
- All table state is flops; no RAM inference, so asynchronous reset applies to every entry.

## Structure
- The shared package btb_pkg holds:
  - the counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
  - the ctr init values for reset and for allocation
  - the opcode constants the resolve stage uses to drive upd_is_jmp
- Sub-module btb_sat_ctr: 2-bit saturating up/down next-state logic, instantiated once per entry or once on the update path.
- Perf counters live inline in btb_predictor.

## Test plan
- After reset, fetch_pc=0x0200 → pred_taken=0, pred_next_pc=0x0202. Both perf counters read 0.
- Train upd_pc=0x0210, taken, target 0x0240, BEQ → next cycle, fetch_pc=0x0210 gives pred_taken=1, pred_next_pc=0x0240 (ctr=10). Two not-taken updates then give pred_taken=0 (ctr 10→01→00).
- Four taken updates at one PC leave ctr=11 (saturated). One not-taken leaves ctr=10, so the branch is still predicted taken.
- With ENTRIES=16, train 0x0210 taken, then 0x0230 taken (same index, different tag) → 0x0210 misses, 0x0230 hits. A not-taken update of a missing PC causes no allocation.
- JMP at 0x0300, target 0x0400, then a not-taken-style decrement → still predicted taken, because is_jmp overrides ctr. Assert clear together with an update → the entry is invalid next cycle and no allocation occurs.
- PERFBITS=4: 20 upd_valid pulses, each with mispredict=1 → both counters hold at 0xF. Async reset mid-update → the counters return to 0 without a clock edge.
